// File: rtl/ariane_soc_pkg.sv
// SoC-wide constants for the error responder: redirect data, decode-error code, FSM states.
package ariane_soc;

  localparam logic [63:0] ERROR_REDIRECT = 64'h0FFF_0FFF_0000_0000;
  localparam logic [1:0]  DECERR         = 2'b11;

  typedef enum logic [1:0] {
    BER_IDLE   = 2'd0,
    BER_WDRAIN = 2'd1,
    BER_BRESP  = 2'd2,
    BER_RBURST = 2'd3
  } ber_state_e;

endpackage

// File: rtl/bus_error_responder.sv
// AXI sink that answers every transaction with DECERR, one transaction at a time.
// Optional address/count logging is built in when BUS_ERR_LOG_EN is defined.
module bus_error_responder
  import ariane_soc::*;
#(
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  input  logic [IdWidth-1:0]  aw_id_i,
  input  logic [63:0]         aw_addr_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic                w_last_i,
  output logic                b_valid_o,
  input  logic                b_ready_i,
  output logic [IdWidth-1:0]  b_id_o,
  output logic [1:0]          b_resp_o,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  input  logic [IdWidth-1:0]  ar_id_i,
  input  logic [63:0]         ar_addr_i,
  input  logic [7:0]          ar_len_i,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  output logic [IdWidth-1:0]  r_id_o,
  output logic [63:0]         r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_last_o,
  output logic [63:0]         err_addr_o,
  output logic [CntWidth-1:0] err_count_o
);

  ber_state_e         state_q, state_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               aw_hs, ar_hs;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign ar_hs = ar_valid_i & ar_ready_o;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BER_IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      BER_IDLE: begin
        if (aw_hs) begin
          state_d = BER_WDRAIN;
          id_d    = aw_id_i;
        end else if (ar_hs) begin
          state_d = BER_RBURST;
          id_d    = ar_id_i;
          cnt_d   = ar_len_i;
        end
      end
      BER_WDRAIN: if (w_valid_i && w_last_i) state_d = BER_BRESP;
      BER_BRESP:  if (b_ready_i) state_d = BER_IDLE;
      BER_RBURST: begin
        if (r_ready_i) begin
          if (cnt_q == 8'd0) state_d = BER_IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      default: state_d = BER_IDLE;
    endcase
  end

  // Handshake outputs; AW wins an IDLE-cycle tie, nothing is accepted while in reset
  always_comb begin
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    case (state_q)
      BER_IDLE: begin
        aw_ready_o = ~rst_i;
        ar_ready_o = ~rst_i & ~aw_valid_i;
      end
      BER_WDRAIN: w_ready_o = 1'b1;
      BER_BRESP:  b_valid_o = 1'b1;
      BER_RBURST: begin
        r_valid_o = 1'b1;
        r_last_o  = (cnt_q == 8'd0);
      end
      default: ;
    endcase
  end

  assign b_id_o   = id_q;
  assign r_id_o   = id_q;
  assign b_resp_o = DECERR;
  assign r_resp_o = DECERR;
  assign r_data_o = ERROR_REDIRECT;

`ifdef BUS_ERR_LOG_EN
  logic [63:0]         err_addr_q;
  logic [CntWidth-1:0] err_count_q;

  // Record the last decoded-away address and a saturating hit count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else if (aw_hs || ar_hs) begin
      err_addr_q <= aw_hs ? aw_addr_i : ar_addr_i;
      if (err_count_q != {CntWidth{1'b1}}) err_count_q <= err_count_q + CntWidth'(1);
    end
  end

  assign err_addr_o  = err_addr_q;
  assign err_count_o = err_count_q;
`else
  logic unused_addr;
  assign unused_addr = ^{aw_addr_i, ar_addr_i};
  assign err_addr_o  = '0;
  assign err_count_o = '0;
`endif

endmodule
